param_reg_file: RTL and testbench

PARAM_REG_FILE -- requirements
Module: param_reg_file

---
 rtl/param_reg_file_pkg.sv | 19 +
 rtl/param_reg_file_if.sv | 29 ++
 rtl/param_reg_file_cell.sv | 47 ++++
 rtl/param_reg_file.sv | 82 ++++++++
 tb/tb_param_reg_file.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/param_reg_file_pkg.sv
// Shared operation encodings for the register-file family (address RF, IR and
// this parameterised file) plus small helpers used by the cells.
package param_reg_file_pkg;

  typedef enum logic [1:0] {
    FS_CLR  = 2'b00,
    FS_LOAD = 2'b01,
    FS_DEC  = 2'b10,
    FS_INC  = 2'b11
  } funsel_e;

  localparam int unsigned NREGS_MIN = 2;
  localparam int unsigned NREGS_MAX = 16;

  function automatic funsel_e to_funsel(input logic [1:0] raw);
    return funsel_e'(raw);
  endfunction

endpackage

// File: rtl/param_reg_file_if.sv
// Operation/read bus of param_reg_file; master drives operations and read
// selects, slave (the register file) returns read data and status.
interface param_reg_file_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8
);
  localparam int IDXW = $clog2(NREGS);

  logic [1:0]       funsel;
  logic [NREGS-1:0] wr_mask;
  logic [WIDTH-1:0] data_in;
  logic [IDXW-1:0]  rd_sel_a;
  logic [IDXW-1:0]  rd_sel_b;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             wrap_flag;
  logic [NREGS-1:0] zero_mask;

  modport master (
    output funsel, wr_mask, data_in, rd_sel_a, rd_sel_b,
    input  out_a, out_b, wrap_flag, zero_mask
  );

  modport slave (
    input  funsel, wr_mask, data_in, rd_sel_a, rd_sel_b,
    output out_a, out_b, wrap_flag, zero_mask
  );

endinterface

// File: rtl/param_reg_file_cell.sv
// param_reg_cell: one WIDTH-bit register applying clear/load/dec/inc when
// enabled; wrap reports that the pending enabled inc/dec rolls over.
module param_reg_cell
  import param_reg_file_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  funsel_e          funsel,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  logic [WIDTH-1:0] d;
  logic             wraps;

  always_comb begin
    d     = q;
    wraps = 1'b0;
    unique case (funsel)
      FS_CLR:  d = '0;
      FS_LOAD: d = data_in;
      FS_DEC: begin
        d     = q - WIDTH'(1);
        wraps = (q == '0);
      end
      FS_INC: begin
        d     = q + WIDTH'(1);
        wraps = (q == '1);
      end
    endcase
  end

  assign wrap = en & wraps;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/param_reg_file.sv
// param_reg_file: NREGS x WIDTH register file with masked clear/load/dec/inc,
// two zero-latency read ports, optional load bypass, wrap and zero status.
module param_reg_file
  import param_reg_file_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NREGS  = 8,
  parameter int BYPASS = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  param_reg_file_if.slave     bus
);

  localparam int IDXW = $clog2(NREGS);

  funsel_e          fs;
  logic [WIDTH-1:0] q [NREGS];
  logic [NREGS-1:0] cell_wrap;
  logic [NREGS-1:0] byp_hit;
  logic [IDXW-1:0]  sel_a;
  logic [IDXW-1:0]  sel_b;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [NREGS-1:0] zero_c;
  logic             wrap_q;

  assign fs    = to_funsel(bus.funsel);
  assign sel_a = bus.rd_sel_a;
  assign sel_b = bus.rd_sel_b;

  for (genvar i = 0; i < NREGS; i++) begin : g_cell
    param_reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (bus.wr_mask[i]),
      .funsel  (fs),
      .data_in (bus.data_in),
      .q       (q[i]),
      .wrap    (cell_wrap[i])
    );
  end

  // Bypass only forwards loads, and never while reset holds the file at zero.
  always_comb begin
    byp_hit = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      byp_hit[i] = (BYPASS != 0) && rst_n && (fs == FS_LOAD) && bus.wr_mask[i];
    end
  end

  // Indices at or beyond NREGS match no entry and read back zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (sel_a == IDXW'(i)) rd_a = byp_hit[i] ? bus.data_in : q[i];
      if (sel_b == IDXW'(i)) rd_b = byp_hit[i] ? bus.data_in : q[i];
    end
  end

  always_comb begin
    zero_c = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      zero_c[i] = (q[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= |cell_wrap;
    end
  end

  assign bus.out_a     = rd_a;
  assign bus.out_b     = rd_b;
  assign bus.zero_mask = zero_c;
  assign bus.wrap_flag = wrap_q;

endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench for param_reg_file: vector table for masked operations plus
// hand sequences for bypass, out-of-range reads and asynchronous reset.
module tb_param_reg_file;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_reg_file_if #(.WIDTH(8), .NREGS(8)) bus_m ();
  param_reg_file_if #(.WIDTH(8), .NREGS(8)) bus_b ();
  param_reg_file_if #(.WIDTH(8), .NREGS(6)) bus_s ();

  param_reg_file #(.WIDTH(8), .NREGS(8), .BYPASS(0)) u_main (
    .clk(clk), .rst_n(rst_n), .bus(bus_m)
  );
  param_reg_file #(.WIDTH(8), .NREGS(8), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );
  param_reg_file #(.WIDTH(8), .NREGS(6), .BYPASS(0)) u_six (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );

  assign bus_b.funsel   = bus_m.funsel;
  assign bus_b.wr_mask  = bus_m.wr_mask;
  assign bus_b.data_in  = bus_m.data_in;
  assign bus_b.rd_sel_a = bus_m.rd_sel_a;
  assign bus_b.rd_sel_b = bus_m.rd_sel_b;

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] fs, input logic [7:0] mask, input logic [7:0] data,
                       input logic [2:0] sa, input logic [2:0] sb);
    bus_m.funsel   = fs;
    bus_m.wr_mask  = mask;
    bus_m.data_in  = data;
    bus_m.rd_sel_a = sa;
    bus_m.rd_sel_b = sb;
  endtask

  typedef struct {
    logic [1:0] fs;
    logic [7:0] mask;
    logic [7:0] data;
    logic [2:0] sa;
    logic [2:0] sb;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       ew;
    logic [7:0] ez;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           fs     mask   data   sa    sb    ea     eb     ew    ez
    tbl[0]  = '{2'b01, 8'h05, 8'h3C, 3'd0, 3'd2, 8'h3C, 8'h3C, 1'b0, 8'hFA};
    tbl[1]  = '{2'b01, 8'h02, 8'hFF, 3'd1, 3'd2, 8'hFF, 8'h3C, 1'b0, 8'hF8};
    tbl[2]  = '{2'b11, 8'h02, 8'h00, 3'd1, 3'd0, 8'h00, 8'h3C, 1'b1, 8'hFA};
    tbl[3]  = '{2'b11, 8'h00, 8'h00, 3'd1, 3'd1, 8'h00, 8'h00, 1'b0, 8'hFA};
    tbl[4]  = '{2'b10, 8'h08, 8'h00, 3'd3, 3'd2, 8'hFF, 8'h3C, 1'b1, 8'hF2};
    tbl[5]  = '{2'b10, 8'h08, 8'h00, 3'd3, 3'd2, 8'hFE, 8'h3C, 1'b0, 8'hF2};
    tbl[6]  = '{2'b11, 8'h05, 8'h00, 3'd0, 3'd2, 8'h3D, 8'h3D, 1'b0, 8'hF2};
    tbl[7]  = '{2'b10, 8'h30, 8'h00, 3'd4, 3'd5, 8'hFF, 8'hFF, 1'b1, 8'hC2};
    tbl[8]  = '{2'b00, 8'h04, 8'h00, 3'd2, 3'd0, 8'h00, 8'h3D, 1'b0, 8'hC6};
    tbl[9]  = '{2'b01, 8'hFF, 8'h00, 3'd3, 3'd3, 8'h00, 8'h00, 1'b0, 8'hFF};
    tbl[10] = '{2'b01, 8'h80, 8'h7F, 3'd7, 3'd7, 8'h7F, 8'h7F, 1'b0, 8'h7F};
    tbl[11] = '{2'b11, 8'hFF, 8'h00, 3'd7, 3'd6, 8'h80, 8'h01, 1'b0, 8'h00};
    tbl[12] = '{2'b10, 8'h7F, 8'h00, 3'd0, 3'd7, 8'h00, 8'h80, 1'b0, 8'h7F};
    tbl[13] = '{2'b10, 8'h01, 8'h00, 3'd0, 3'd1, 8'hFF, 8'h00, 1'b1, 8'h7E};
    tbl[14] = '{2'b00, 8'hFF, 8'h00, 3'd0, 3'd7, 8'h00, 8'h00, 1'b0, 8'hFF};

    // Operation requested during reset must be ignored.
    drive(2'b11, 8'hFF, 8'h00, 3'd0, 3'd7);
    bus_s.funsel = 2'b00; bus_s.wr_mask = '0; bus_s.data_in = '0;
    bus_s.rd_sel_a = '0; bus_s.rd_sel_b = '0;
    #12;
    check("rst_out_a", bus_m.out_a, 8'h00);
    check("rst_out_b", bus_m.out_b, 8'h00);
    check("rst_zero", bus_m.zero_mask, 8'hFF);
    check("rst_wrap", {7'd0, bus_m.wrap_flag}, 8'h00);

    @(negedge clk);
    drive(2'b00, 8'h00, 8'h00, 3'd0, 3'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tbl[i].fs, tbl[i].mask, tbl[i].data, tbl[i].sa, tbl[i].sb);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_a", i), bus_m.out_a, tbl[i].ea);
      check($sformatf("v%0d_out_b", i), bus_m.out_b, tbl[i].eb);
      check($sformatf("v%0d_wrap", i), {7'd0, bus_m.wrap_flag}, {7'd0, tbl[i].ew});
      check($sformatf("v%0d_zero", i), bus_m.zero_mask, tbl[i].ez);
    end

    // Bypass of a load into R4, then confirm clear is not bypassed.
    @(negedge clk);
    drive(2'b01, 8'h10, 8'hA5, 3'd4, 3'd4);
    #1;
    check("byp_pre_edge", bus_b.out_a, 8'hA5);
    check("nobyp_pre_edge", bus_m.out_a, 8'h00);
    @(posedge clk);
    #1;
    check("nobyp_post_edge", bus_m.out_a, 8'hA5);
    check("byp_post_edge", bus_b.out_b, 8'hA5);
    @(negedge clk);
    drive(2'b00, 8'h10, 8'h00, 3'd4, 3'd4);
    #1;
    check("byp_clr_pre_edge", bus_b.out_a, 8'hA5);
    @(posedge clk);
    #1;
    check("byp_clr_post_edge", bus_b.out_a, 8'h00);
    @(negedge clk);
    drive(2'b11, 8'h10, 8'h00, 3'd4, 3'd4);
    #1;
    check("byp_inc_pre_edge", bus_b.out_a, 8'h00);
    @(posedge clk);
    #1;
    check("byp_inc_post_edge", bus_b.out_a, 8'h01);

    // Six-register file: index 6/7 are out of range.
    @(negedge clk);
    drive(2'b00, 8'h00, 8'h00, 3'd0, 3'd0);
    bus_s.funsel = 2'b01; bus_s.wr_mask = 6'h3F; bus_s.data_in = 8'h11;
    bus_s.rd_sel_a = 3'd5; bus_s.rd_sel_b = 3'd7;
    @(posedge clk);
    #1;
    check("six_in_range", bus_s.out_a, 8'h11);
    check("six_sel7", bus_s.out_b, 8'h00);
    check("six_zero", {2'b00, bus_s.zero_mask}, 8'h00);
    bus_s.wr_mask = '0;
    bus_s.rd_sel_b = 3'd6;
    #1;
    check("six_sel6", bus_s.out_b, 8'h00);

    // Reset asserted between edges with a wrap pending on wrap_flag.
    @(negedge clk);
    drive(2'b01, 8'h01, 8'hFF, 3'd1, 3'd0);
    @(negedge clk);
    drive(2'b01, 8'hFE, 8'h10, 3'd1, 3'd0);
    @(negedge clk);
    drive(2'b11, 8'hFF, 8'h00, 3'd1, 3'd0);
    @(posedge clk);
    #1;
    check("pre_rst_wrap", {7'd0, bus_m.wrap_flag}, 8'h01);
    check("pre_rst_out_a", bus_m.out_a, 8'h11);
    check("pre_rst_zero", bus_m.zero_mask, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_a", bus_m.out_a, 8'h00);
    check("mid_rst_zero", bus_m.zero_mask, 8'hFF);
    check("mid_rst_wrap", {7'd0, bus_m.wrap_flag}, 8'h00);
    @(posedge clk);
    #1;
    check("rst_hold_out_a", bus_m.out_a, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_out_a", bus_m.out_a, 8'h01);
    check("post_rst_out_b", bus_m.out_b, 8'h01);
    check("post_rst_zero", bus_m.zero_mask, 8'h00);
    check("post_rst_wrap", {7'd0, bus_m.wrap_flag}, 8'h00);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
